// File: rtl/light_pkg.sv
// Shared types and constants for the light level sequencer.
package light_pkg;
  localparam int LEVEL_W       = 3;
  localparam int MAX_LEVEL_DEF = 4;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_STEADY,
    ST_RAMP,
    ST_FADE
  } light_state_e;

  // RAMP and FADE are the two states in which the level is still moving.
  function automatic logic is_moving(light_state_e s);
    return (s == ST_RAMP) || (s == ST_FADE);
  endfunction
endpackage

// File: rtl/light_tick_timer.sv
// Free-running tick counter with synchronous clear; o_tc flags the last
// count of each TICKS-long period while enabled.
module light_tick_timer #(
  parameter int TICKS = 4
)(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tc   = i_en & w_last;

  // Count while enabled, wrap after the last tick; clear wins over enable.
  always_ff @(posedge i_clk) begin
    if (!i_reset)    r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/light_level_sequencer.sv
// Brightness sequencer: buttons move a target level, the output level
// walks one step per STEP_TICKS toward it, and an idle timer fades the
// light out after IDLE_TICKS of inactivity in a steady state.
module light_level_sequencer
  import light_pkg::*;
#(
  parameter int STEP_TICKS = 5_000_000,
  parameter int IDLE_TICKS = 1_000_000_000,
  parameter int MAX_LEVEL  = MAX_LEVEL_DEF
)(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [2:0]         i_button,
  input  logic               i_auto_off_en,
  output logic [LEVEL_W-1:0] o_lightState,
  output logic [LEVEL_W-1:0] o_target,
  output logic               o_busy,
  output logic               o_timeout
);
  localparam logic [LEVEL_W-1:0] LMAX = LEVEL_W'(MAX_LEVEL);

  light_state_e       r_state, w_state_n;
  logic [LEVEL_W-1:0] r_lvl, r_tgt, w_lvl_n, w_tgt_n;
  logic w_up, w_dn, w_off, w_any;
  logic w_step_tc, w_step_clr;
  logic w_idle_tc, w_idle_en, w_idle_clr;
  logic w_timeout;

  // off beats everything; up together with down cancels out
  assign w_off = i_button[2];
  assign w_up  = i_button[0] & ~i_button[1] & ~i_button[2];
  assign w_dn  = i_button[1] & ~i_button[0] & ~i_button[2];
  assign w_any = |i_button;

  // Step period only runs while the level is heading somewhere; holding it
  // cleared in OFF/STEADY makes the first step land STEP_TICKS after entry.
  assign w_step_clr = ~is_moving(w_state_n);

  light_tick_timer #(.TICKS(STEP_TICKS)) u_step_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_step_clr),
    .i_en    (1'b1),
    .o_tc    (w_step_tc)
  );

  assign w_idle_en  = (r_state == ST_STEADY) & i_auto_off_en;
  assign w_idle_clr = w_any | ~w_idle_en;

  light_tick_timer #(.TICKS(IDLE_TICKS)) u_idle_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_idle_clr),
    .i_en    (w_idle_en),
    .o_tc    (w_idle_tc)
  );

  // Next target/level/state from buttons, idle expiry and step ticks.
  always_comb begin
    w_state_n = r_state;
    w_tgt_n   = r_tgt;
    w_lvl_n   = r_lvl;
    w_timeout = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_up) begin
          w_tgt_n   = (LMAX != '0) ? LEVEL_W'(1) : '0;
          w_state_n = ST_RAMP;
        end
      end
      ST_STEADY: begin
        if (w_off) begin
          w_tgt_n   = '0;
          w_state_n = ST_FADE;
        end else if (w_up) begin
          if (r_tgt != LMAX) begin
            w_tgt_n   = r_tgt + 1'b1;
            w_state_n = ST_RAMP;
          end
        end else if (w_dn) begin
          w_tgt_n   = r_tgt - 1'b1;
          w_state_n = ST_RAMP;
        end else if (w_idle_tc && !w_any) begin
          w_tgt_n   = '0;
          w_state_n = ST_FADE;
          w_timeout = 1'b1;
        end
      end
      ST_RAMP: begin
        if (w_off) begin
          w_tgt_n   = '0;
          w_state_n = ST_FADE;
        end else if (w_up) begin
          if (r_tgt != LMAX) w_tgt_n = r_tgt + 1'b1;
        end else if (w_dn) begin
          if (r_tgt != '0) w_tgt_n = r_tgt - 1'b1;
        end
      end
      ST_FADE: begin
        // up during a fade restarts from just above the current level
        if (w_up) begin
          w_tgt_n   = (r_lvl >= LMAX) ? LMAX : r_lvl + 1'b1;
          w_state_n = ST_RAMP;
        end
      end
      default: w_state_n = ST_OFF;
    endcase

    if (is_moving(r_state) && w_step_tc) begin
      if (r_lvl < w_tgt_n)      w_lvl_n = r_lvl + 1'b1;
      else if (r_lvl > w_tgt_n) w_lvl_n = r_lvl - 1'b1;
    end

    // settle as soon as the level meets the target
    if (is_moving(w_state_n) && (w_lvl_n == w_tgt_n))
      w_state_n = (w_tgt_n == '0) ? ST_OFF : ST_STEADY;
  end

  // State, level and target registers; reset drops straight to dark.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_OFF;
      r_lvl   <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_lvl   <= w_lvl_n;
      r_tgt   <= w_tgt_n;
    end
  end

  assign o_lightState = r_lvl;
  assign o_target     = r_tgt;
  assign o_busy       = (r_lvl != r_tgt);
  assign o_timeout    = w_timeout & i_reset;
endmodule

// File: tb/tb_light_level_sequencer.sv
// Directed bench for light_level_sequencer with a timestamp-based model.
module tb_light_level_sequencer;
  localparam int STEP = 4, IDLE = 20, MAXL = 4;
  localparam int OFF = 0, STD = 1, RMP = 2, FAD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn = 3'b000;
  logic       aen = 1'b0;
  logic [2:0] lvl, tgt;
  logic       busy, tmo;

  always #5 clk = ~clk;

  light_level_sequencer #(.STEP_TICKS(STEP), .IDLE_TICKS(IDLE), .MAX_LEVEL(MAXL)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_button(btn), .i_auto_off_en(aen),
    .o_lightState(lvl), .o_target(tgt), .o_busy(busy), .o_timeout(tmo)
  );

  int n_vec = 0, n_bad = 0, cyc = 0;
  int m_lvl = 0, m_tgt = 0, m_mode = OFF, m_next = 0, m_idle0 = 0;
  bit m_ok = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit moving(input int m);
    return (m == RMP) || (m == FAD);
  endfunction

  // auto-off fires in the cycle the quiet STEADY stretch reaches IDLE cycles
  function automatic bit exp_tmo();
    return rst_n && (m_mode == STD) && aen && (btn == 3'b000) && (cyc - m_idle0 == IDLE - 1);
  endfunction

  // Model: absolute cycle stamps for the next step and for the start of idle.
  always @(posedge clk) begin : model
    bit up, dn, off, fire;
    int pm;
    up  = btn[0] && !btn[1] && !btn[2];
    dn  = btn[1] && !btn[0] && !btn[2];
    off = btn[2];
    if (!rst_n) begin
      m_lvl = 0; m_tgt = 0; m_mode = OFF; m_idle0 = cyc + 1; m_ok = 1;
    end else begin
      fire = exp_tmo();
      pm   = m_mode;
      case (m_mode)
        OFF: if (up) begin m_tgt = 1; m_mode = RMP; end
        STD: begin
          if (off) begin m_tgt = 0; m_mode = FAD; end
          else if (up) begin if (m_tgt < MAXL) begin m_tgt++; m_mode = RMP; end end
          else if (dn) begin m_tgt--; m_mode = RMP; end
          else if (fire) begin m_tgt = 0; m_mode = FAD; end
        end
        RMP: begin
          if (off) begin m_tgt = 0; m_mode = FAD; end
          else if (up) m_tgt = (m_tgt < MAXL) ? m_tgt + 1 : MAXL;
          else if (dn) m_tgt = (m_tgt > 0) ? m_tgt - 1 : 0;
        end
        default: if (up) begin m_tgt = (m_lvl + 1 < MAXL) ? m_lvl + 1 : MAXL; m_mode = RMP; end
      endcase
      if (!moving(pm) && moving(m_mode)) m_next = cyc + STEP;
      if (moving(pm) && (cyc + 1 == m_next)) begin
        if (m_lvl < m_tgt) m_lvl++;
        else if (m_lvl > m_tgt) m_lvl--;
        m_next += STEP;
      end
      if (moving(m_mode) && m_lvl == m_tgt) m_mode = (m_tgt == 0) ? OFF : STD;
      if (btn != 3'b000 || !aen || pm != STD) m_idle0 = cyc + 1;
    end
    cyc++;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_level",   32'(lvl),  32'(m_lvl));
      chk("model_target",  32'(tgt),  32'(m_tgt));
      chk("model_busy",    32'(busy), 32'(m_lvl != m_tgt));
      chk("model_timeout", 32'(tmo),  32'(exp_tmo()));
    end
  end

  task automatic step1(); @(posedge clk); #1; endtask
  task automatic goto(input int c); while (cyc < c) step1(); endtask
  task automatic at(input int c); goto(c); #1; endtask
  task automatic pulse(input logic [2:0] b); btn = b; step1(); btn = 3'b000; endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, t1, t2, s, p, u, r;
    // reset with an up pulse held on the button lines: must be discarded
    btn = 3'b001;
    at(3);
    chk("rst_level", 32'(lvl), 0); chk("rst_target", 32'(tgt), 0);
    chk("rst_busy", 32'(busy), 0); chk("rst_timeout", 32'(tmo), 0);
    btn = 3'b000; rst_n = 1'b1;

    // single up from OFF
    t0 = cyc + 2; goto(t0); pulse(3'b001);
    at(t0 + 1); chk("up1_target", 32'(tgt), 1); chk("up1_busy", 32'(busy), 1);
    at(t0 + 3); chk("up1_level_c3", 32'(lvl), 0);
    at(t0 + 4); chk("up1_level_c4", 32'(lvl), 1); chk("up1_busy_c4", 32'(busy), 0);
    goto(t0 + 5); pulse(3'b010);
    at(t0 + 9); chk("down_to_off", 32'(lvl), 0);

    // five consecutive ups saturate at MAX
    t0 = cyc + 1; goto(t0);
    for (int i = 0; i < 5; i++) pulse(3'b001);
    at(t0 + 5);  chk("sat_target", 32'(tgt), 4); chk("sat_level_c5", 32'(lvl), 1);
    at(t0 + 8);  chk("sat_level_c8", 32'(lvl), 2);
    at(t0 + 12); chk("sat_level_c12", 32'(lvl), 3);
    at(t0 + 15); chk("sat_level_c15", 32'(lvl), 3);
    at(t0 + 16); chk("sat_level_c16", 32'(lvl), 4); chk("sat_busy_c16", 32'(busy), 0);

    // down to 3, then off -> fade
    t1 = t0 + 17; goto(t1); pulse(3'b010);
    at(t1 + 4); chk("lvl3_steady", 32'(lvl), 3);
    t2 = t1 + 6; goto(t2); pulse(3'b100);
    at(t2 + 1);  chk("fade_target", 32'(tgt), 0); chk("fade_busy", 32'(busy), 1);
    at(t2 + 4);  chk("fade_level_4", 32'(lvl), 2);
    at(t2 + 8);  chk("fade_level_8", 32'(lvl), 1);
    at(t2 + 12); chk("fade_level_12", 32'(lvl), 0); chk("fade_busy_12", 32'(busy), 0);
    pulse(3'b100); pulse(3'b010);
    at(t2 + 15); chk("off_ignores", 32'(tgt), 0);

    // idle auto-off from level 2
    t0 = cyc + 1; goto(t0); pulse(3'b001); pulse(3'b001);
    at(t0 + 8); chk("idle_lvl2", 32'(lvl), 2);
    s = t0 + 10; goto(s); aen = 1'b1;
    at(s + 18); chk("idle_no_tmo_18", 32'(tmo), 0);
    at(s + 19); chk("idle_tmo_19", 32'(tmo), 1); chk("idle_tgt_19", 32'(tgt), 2);
    at(s + 20); chk("idle_tmo_20", 32'(tmo), 0); chk("idle_tgt_20", 32'(tgt), 0);
    at(s + 23); chk("idle_level_23", 32'(lvl), 1);
    at(s + 26); chk("idle_level_26", 32'(lvl), 1);
    at(s + 27); chk("idle_level_27", 32'(lvl), 0);

    // button in the expiry cycle beats the timeout
    t0 = cyc + 1; goto(t0); pulse(3'b001);
    goto(t0 + 23); btn = 3'b001; #1;
    chk("expiry_btn_tmo", 32'(tmo), 0);
    step1(); btn = 3'b000;
    at(t0 + 24); chk("expiry_btn_tgt", 32'(tgt), 2); aen = 1'b0;
    at(t0 + 27); chk("expiry_btn_lvl", 32'(lvl), 2);

    // up+down cancels; off+up fades; down ignored and up re-ramps in fade
    t0 = cyc + 1; goto(t0); pulse(3'b011);
    at(t0 + 1); chk("updown_tgt", 32'(tgt), 2); chk("updown_busy", 32'(busy), 0);
    p = cyc; pulse(3'b101);
    at(p + 1); chk("offup_tgt", 32'(tgt), 0); pulse(3'b010);
    at(p + 2); chk("fade_dn_ign", 32'(tgt), 0);
    at(p + 4); chk("fade_lvl1", 32'(lvl), 1); pulse(3'b001);
    at(p + 5); chk("fade_up_tgt", 32'(tgt), 2);
    at(p + 7); chk("fade_up_lvl7", 32'(lvl), 1);
    at(p + 8); chk("fade_up_lvl8", 32'(lvl), 2); chk("fade_up_busy", 32'(busy), 0);

    // reset mid-ramp at level 2
    t0 = cyc + 1; goto(t0); pulse(3'b100);
    u = t0 + 9; goto(u);
    for (int i = 0; i < 4; i++) pulse(3'b001);
    r = u + 9; at(r); chk("pre_rst_lvl", 32'(lvl), 2); chk("pre_rst_tgt", 32'(tgt), 4);
    rst_n = 1'b0;
    at(r + 1);
    chk("mid_rst_lvl", 32'(lvl), 0); chk("mid_rst_tgt", 32'(tgt), 0);
    chk("mid_rst_busy", 32'(busy), 0); chk("mid_rst_tmo", 32'(tmo), 0);
    rst_n = 1'b1; pulse(3'b001);
    at(r + 2); chk("post_rst_tgt", 32'(tgt), 1);
    at(r + 4); chk("post_rst_lvl4", 32'(lvl), 0);
    at(r + 5); chk("post_rst_lvl5", 32'(lvl), 1);

    goto(cyc + 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
